cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_arb_pkg.sv | 17 +
 rtl/cache_mem_arbiter_watchdog.sv | 30 +++
 rtl/cache_mem_arbiter.sv | 114 +++++++++++
 tb/tb_cache_mem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared types and defaults for the cache memory arbiter
package cache_arb_pkg;

    localparam int CACHE_ARB_ADDR_W = 32;
    localparam int CACHE_ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } arb_state_t;

    function automatic logic [1:0] grant_onehot(input logic grant);
        return grant ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_watchdog.sv
// rtl/cache_mem_arbiter_watchdog.sv - ACCESS-state timeout counter
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [CNT_W-1:0] r_count;

    // r_count holds completed ACCESS cycles; expiry fires in the TIMEOUT_CYCLES-th one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && enable && (r_count == LIMIT);

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - two-requester round-robin arbiter onto a single memory port
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W         = CACHE_ARB_ADDR_W,
    parameter int DATA_W         = CACHE_ARB_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0][ADDR_W-1:0] req_address,
    input  logic [1:0]             req_read_enable,
    input  logic [1:0]             req_write_enable,
    input  logic [1:0][DATA_W-1:0] req_write_data,
    output logic [DATA_W-1:0]      req_read_data,
    output logic [1:0]             req_ack,
    output logic [ADDR_W-1:0]      mem_address,
    output logic [DATA_W-1:0]      mem_write_data,
    output logic                   mem_read_enable,
    output logic                   mem_write_enable,
    input  logic [DATA_W-1:0]      mem_read_data,
    input  logic                   mem_ack,
    output logic                   timeout_error,
    output logic                   busy
);

    arb_state_t        r_state;
    logic              r_last_grant;
    logic              r_grant;
    logic              r_is_write;
    logic              r_timed_out;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_write_data;
    logic [DATA_W-1:0] r_rdata;

    logic [1:0]        w_pending;
    logic              w_grant;
    logic              w_start;
    logic              w_in_access;
    logic              w_expired;

    always_comb begin
        w_pending   = req_read_enable | req_write_enable;
        w_start     = (r_state == IDLE) && (|w_pending);
        w_in_access = (r_state == ACCESS);
        // On a tie the requester that did not win last time goes next
        w_grant     = (&w_pending) ? ~r_last_grant : w_pending[1];
    end

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_start),
        .enable (w_in_access),
        .expired(w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_last_grant     <= 1'b1;
            r_grant          <= 1'b0;
            r_is_write       <= 1'b0;
            r_timed_out      <= 1'b0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
            r_rdata          <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_grant          <= w_grant;
                        r_mem_address    <= req_address[w_grant];
                        r_mem_write_data <= req_write_data[w_grant];
                        r_is_write       <= req_write_enable[w_grant];
                        r_timed_out      <= 1'b0;
                        r_state          <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Timeout takes priority over a coincident mem_ack
                    if (w_expired) begin
                        r_rdata     <= '0;
                        r_timed_out <= 1'b1;
                        r_state     <= RESPOND;
                    end else if (mem_ack) begin
                        r_rdata     <= r_is_write ? '0 : mem_read_data;
                        r_timed_out <= 1'b0;
                        r_state     <= RESPOND;
                    end
                end
                RESPOND: begin
                    r_last_grant <= r_grant;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy             = (r_state != IDLE);
    assign req_ack          = (r_state == RESPOND) ? grant_onehot(r_grant) : 2'b00;
    assign req_read_data    = (r_state == RESPOND) ? r_rdata : '0;
    assign timeout_error    = (r_state == RESPOND) && r_timed_out;
    assign mem_read_enable  = w_in_access && !r_is_write;
    assign mem_write_enable = w_in_access && r_is_write;
    assign mem_address      = r_mem_address;
    assign mem_write_data   = r_mem_write_data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0][AW-1:0] req_address;
    logic [1:0]         req_read_enable;
    logic [1:0]         req_write_enable;
    logic [1:0][DW-1:0] req_write_data;
    logic [DW-1:0]      req_read_data;
    logic [1:0]         req_ack;
    logic [AW-1:0]      mem_address;
    logic [DW-1:0]      mem_write_data;
    logic               mem_read_enable;
    logic               mem_write_enable;
    logic [DW-1:0]      mem_read_data;
    logic               mem_ack;
    logic               timeout_error;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_address     (req_address),
        .req_read_enable (req_read_enable),
        .req_write_enable(req_write_enable),
        .req_write_data  (req_write_data),
        .req_read_data   (req_read_data),
        .req_ack         (req_ack),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_read_enable (mem_read_enable),
        .mem_write_enable(mem_write_enable),
        .mem_read_data   (mem_read_data),
        .mem_ack         (mem_ack),
        .timeout_error   (timeout_error),
        .busy            (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_address      = '0;
        req_read_enable  = 2'b00;
        req_write_enable = 2'b00;
        req_write_data   = '0;
        mem_read_data    = '0;
        mem_ack          = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_ack", req_ack, 0);
        check("rst_ren", mem_read_enable, 0);
        check("rst_wen", mem_write_enable, 0);
        check("rst_addr", mem_address, 0);
        check("rst_wdata", mem_write_data, 0);
        check("rst_rdata", req_read_data, 0);
        check("rst_tmo", timeout_error, 0);

        // single read by r0, mem_ack in the second ACCESS cycle
        req_address[0]     = 32'h0000_0040;
        req_read_enable[0] = 1'b1;
        tick();
        check("rd_ren", mem_read_enable, 1);
        check("rd_wen", mem_write_enable, 0);
        check("rd_addr", mem_address, 32'h40);
        check("rd_busy", busy, 1);
        check("rd_ack_early", req_ack, 0);
        tick();
        check("rd_ren_c2", mem_read_enable, 1);
        mem_ack       = 1'b1;
        mem_read_data = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        check("rd_ack", req_ack, 2'b01);
        check("rd_data", req_read_data, 32'hDEAD_BEEF);
        check("rd_ren_resp", mem_read_enable, 0);
        check("rd_tmo", timeout_error, 0);
        req_read_enable = 2'b00;
        tick();
        check("rd_idle_ack", req_ack, 0);
        check("rd_idle_busy", busy, 0);
        check("rd_idle_data", req_read_data, 0);

        // tie after reset: alternating grants starting with r0
        do_reset();
        req_address[0]  = 32'h0000_0200;
        req_address[1]  = 32'h0000_0300;
        req_read_enable = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("tie_addr", mem_address, (k % 2 == 0) ? 32'h200 : 32'h300);
            check("tie_ren", mem_read_enable, 1);
            mem_ack       = 1'b1;
            mem_read_data = 32'hC0DE_0000 + 32'(k);
            tick();
            mem_ack = 1'b0;
            check("tie_ack", req_ack, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("tie_data", req_read_data, 32'hC0DE_0000 + 32'(k));
            tick();
            check("tie_idle", busy, 0);
        end
        req_read_enable = 2'b00;

        // write from r1 with read also asserted: treated as write
        req_address[1]      = 32'h0000_0100;
        req_write_data[1]   = 32'h1234_5678;
        req_write_enable[1] = 1'b1;
        req_read_enable[1]  = 1'b1;
        tick();
        check("wr_wen", mem_write_enable, 1);
        check("wr_ren", mem_read_enable, 0);
        check("wr_addr", mem_address, 32'h100);
        check("wr_data", mem_write_data, 32'h1234_5678);
        req_address[1]    = 32'h0000_0BAD;
        req_write_data[1] = 32'hFFFF_0000;
        tick();
        check("wr_wen_c2", mem_write_enable, 1);
        check("wr_addr_c2", mem_address, 32'h100);
        check("wr_data_c2", mem_write_data, 32'h1234_5678);
        mem_ack       = 1'b1;
        mem_read_data = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        check("wr_ack", req_ack, 2'b10);
        check("wr_rdata", req_read_data, 0);
        check("wr_wen_resp", mem_write_enable, 0);
        req_write_enable = 2'b00;
        req_read_enable  = 2'b00;
        tick();

        // timeout after 4 ACCESS cycles; coincident mem_ack loses
        req_address[0]     = 32'h0000_0080;
        req_read_enable[0] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("to_ren", mem_read_enable, 1);
            check("to_ack_wait", req_ack, 0);
            if (c == 4) begin
                mem_ack       = 1'b1;
                mem_read_data = 32'hAAAA_5555;
            end
        end
        tick();
        mem_ack = 1'b0;
        check("to_ack", req_ack, 2'b01);
        check("to_err", timeout_error, 1);
        check("to_data", req_read_data, 0);
        req_read_enable = 2'b00;
        tick();
        check("to_err_clr", timeout_error, 0);
        check("to_busy", busy, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("stray_busy", busy, 0);
        check("stray_ack", req_ack, 0);
        tick();
        check("stray_ack2", req_ack, 0);

        // reset in the middle of ACCESS
        req_address[1]     = 32'h0000_0044;
        req_read_enable[1] = 1'b1;
        tick();
        check("mid_ren", mem_read_enable, 1);
        rst = 1'b1;
        #1;
        check("mid_ren_rst", mem_read_enable, 0);
        check("mid_busy_rst", busy, 0);
        check("mid_ack_rst", req_ack, 0);
        check("mid_addr_rst", mem_address, 0);
        tick();
        rst             = 1'b0;
        req_read_enable = 2'b00;
        mem_ack         = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("mid_late_ack", req_ack, 0);
        check("mid_late_busy", busy, 0);
        tick();
        check("mid_late_ack2", req_ack, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
